// File: rtl/instr_reg_scheduler_if.sv
// Bus between the instruction-register scheduler and its producers/consumer/register.
// master: scheduler side. slave: producers, consumer and instruction register side.
interface instr_reg_scheduler_if #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned DEPTH   = 32,
   parameter int unsigned PTR_W   = $clog2(DEPTH)
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [4*NUM_REQ-1:0]  req_opcode;
   logic [32*NUM_REQ-1:0] req_operand_a;
   logic [32*NUM_REQ-1:0] req_operand_b;
   logic [NUM_REQ-1:0]    req_ready;
   logic                  load_en;
   logic [3:0]            opcode;
   logic signed [31:0]    operand_a;
   logic signed [31:0]    operand_b;
   logic [PTR_W-1:0]      write_pointer;
   logic                  rd_req;
   logic                  rd_ready;
   logic [PTR_W-1:0]      read_pointer;
   logic                  rd_valid;
   logic [PTR_W:0]        count;
   logic                  full;
   logic                  empty;

   modport master (
      input  req_valid, req_opcode, req_operand_a, req_operand_b, rd_req,
      output req_ready, load_en, opcode, operand_a, operand_b, write_pointer,
             rd_ready, read_pointer, rd_valid, count, full, empty
   );

   modport slave (
      output req_valid, req_opcode, req_operand_a, req_operand_b, rd_req,
      input  req_ready, load_en, opcode, operand_a, operand_b, write_pointer,
             rd_ready, read_pointer, rd_valid, count, full, empty
   );
endinterface

// File: rtl/instr_reg_scheduler.sv
// Write/read sequencer and round-robin arbiter for the instruction register.
// Optional feature: define INSTR_SCHED_CLEAR_EN to zero all DEPTH entries after reset.
module instr_reg_scheduler #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned DEPTH   = 32,
   parameter int unsigned PTR_W   = $clog2(DEPTH)
) (
   input logic                  i_clk,
   input logic                  i_reset,
   instr_reg_scheduler_if.master io_bus
);

   localparam int unsigned GRANT_W = $clog2(NUM_REQ);

`ifdef INSTR_SCHED_CLEAR_EN
   typedef enum logic [0:0] {StClear, StRun} state_e;
`else
   typedef enum logic [0:0] {StRun} state_e;
`endif

   state_e               r_state;
   logic                 r_load_en;
   logic [3:0]           r_opcode;
   logic signed [31:0]   r_operand_a;
   logic signed [31:0]   r_operand_b;
   logic [PTR_W-1:0]     r_write_pointer;
   logic [PTR_W-1:0]     r_read_pointer;
   logic                 r_rd_valid;
   logic [PTR_W:0]       r_count;
   logic [PTR_W-1:0]     r_wp;
   logic [PTR_W-1:0]     r_rp;
   logic [GRANT_W-1:0]   r_last_grant;
`ifdef INSTR_SCHED_CLEAR_EN
   logic [PTR_W-1:0]     r_clr_idx;
`endif

   logic                 w_run;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_rd_ready;
   logic                 w_wr_acc;
   logic                 w_rd_acc;
   logic [NUM_REQ-1:0]   w_grant;
   logic [NUM_REQ-1:0]   w_req_ready;
   logic [GRANT_W-1:0]   w_grant_idx;
   logic [GRANT_W-1:0]   w_idx;
   int unsigned          w_pos;
   logic                 w_found;
   logic [3:0]           w_sel_opcode;
   logic signed [31:0]   w_sel_operand_a;
   logic signed [31:0]   w_sel_operand_b;

   assign w_run       = (r_state == StRun);
   assign w_full      = (r_count == (PTR_W+1)'(DEPTH));
   assign w_empty     = (r_count == '0);
   assign w_rd_ready  = w_run && !w_empty;
   assign w_req_ready = (w_run && !w_full) ? w_grant : '0;
   assign w_wr_acc    = |(io_bus.req_valid & w_req_ready);
   assign w_rd_acc    = io_bus.rd_req && w_rd_ready;

   // Round-robin pick: first valid requester after last_grant, with wrap; mux its fields.
   always_comb begin
      w_grant         = '0;
      w_grant_idx     = '0;
      w_idx           = '0;
      w_pos           = 0;
      w_found         = 1'b0;
      w_sel_opcode    = '0;
      w_sel_operand_a = '0;
      w_sel_operand_b = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         w_pos = (32'(r_last_grant) + 1 + k) % NUM_REQ;
         w_idx = GRANT_W'(w_pos);
         if (!w_found && io_bus.req_valid[w_idx]) begin
            w_found          = 1'b1;
            w_grant[w_idx]   = 1'b1;
            w_grant_idx      = w_idx;
         end
      end
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (w_grant[k]) begin
            w_sel_opcode    = io_bus.req_opcode[4*k +: 4];
            w_sel_operand_a = io_bus.req_operand_a[32*k +: 32];
            w_sel_operand_b = io_bus.req_operand_b[32*k +: 32];
         end
      end
   end

   // FSM with registered output stage, pointers, occupancy and arbitration history.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
`ifdef INSTR_SCHED_CLEAR_EN
         r_state   <= StClear;
         r_clr_idx <= '0;
`else
         r_state   <= StRun;
`endif
         r_load_en       <= 1'b0;
         r_opcode        <= '0;
         r_operand_a     <= '0;
         r_operand_b     <= '0;
         r_write_pointer <= '0;
         r_read_pointer  <= '0;
         r_rd_valid      <= 1'b0;
         r_count         <= '0;
         r_wp            <= '0;
         r_rp            <= '0;
         r_last_grant    <= GRANT_W'(NUM_REQ - 1);
      end else begin
         r_load_en  <= 1'b0;
         r_rd_valid <= 1'b0;
         unique case (r_state)
`ifdef INSTR_SCHED_CLEAR_EN
            StClear: begin
               r_load_en       <= 1'b1;
               r_opcode        <= '0;
               r_operand_a     <= '0;
               r_operand_b     <= '0;
               r_write_pointer <= r_clr_idx;
               r_clr_idx       <= r_clr_idx + PTR_W'(1);
               if (r_clr_idx == PTR_W'(DEPTH - 1)) begin
                  r_state <= StRun;
               end
            end
`endif
            StRun: begin
               if (w_wr_acc) begin
                  r_load_en       <= 1'b1;
                  r_opcode        <= w_sel_opcode;
                  r_operand_a     <= w_sel_operand_a;
                  r_operand_b     <= w_sel_operand_b;
                  r_write_pointer <= r_wp;
                  r_wp            <= r_wp + PTR_W'(1);
                  r_last_grant    <= w_grant_idx;
               end
               if (w_rd_acc) begin
                  r_read_pointer <= r_rp;
                  r_rp           <= r_rp + PTR_W'(1);
                  r_rd_valid     <= 1'b1;
               end
               if (w_wr_acc && !w_rd_acc) begin
                  r_count <= r_count + (PTR_W+1)'(1);
               end else if (w_rd_acc && !w_wr_acc) begin
                  r_count <= r_count - (PTR_W+1)'(1);
               end
            end
            default: r_state <= StRun;
         endcase
      end
   end

   assign io_bus.req_ready     = w_req_ready;
   assign io_bus.load_en       = r_load_en;
   assign io_bus.opcode        = r_opcode;
   assign io_bus.operand_a     = r_operand_a;
   assign io_bus.operand_b     = r_operand_b;
   assign io_bus.write_pointer = r_write_pointer;
   assign io_bus.rd_ready      = w_rd_ready;
   assign io_bus.read_pointer  = r_read_pointer;
   assign io_bus.rd_valid      = r_rd_valid;
   assign io_bus.count         = r_count;
   assign io_bus.full          = w_full;
   assign io_bus.empty         = w_empty;

endmodule

// File: tb/tb_instr_reg_scheduler.sv
// Directed bench for instr_reg_scheduler; covers the CLEAR sequence when
// INSTR_SCHED_CLEAR_EN is defined.
module tb_instr_reg_scheduler;

   localparam int unsigned NUM_REQ = 2;
   localparam int unsigned DEPTH   = 32;
   localparam int unsigned PTR_W   = 5;
   localparam logic [3:0]  OP_ADD  = 4'd1;
   localparam logic [3:0]  OP_SUB  = 4'd2;
   localparam logic [3:0]  OP_MULT = 4'd3;

   logic i_clk = 1'b0;
   logic i_reset;
   int   n_cmp  = 0;
   int   n_fail = 0;

   instr_reg_scheduler_if #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH), .PTR_W(PTR_W)) bus ();

   instr_reg_scheduler #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .io_bus (bus.master)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic set_req(input int r, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b);
      bus.req_opcode[4*r +: 4]      = op;
      bus.req_operand_a[32*r +: 32] = a;
      bus.req_operand_b[32*r +: 32] = b;
   endtask

   initial begin
      i_reset           = 1'b1;
      bus.req_valid     = '0;
      bus.req_opcode    = '0;
      bus.req_operand_a = '0;
      bus.req_operand_b = '0;
      bus.rd_req        = 1'b0;
      cyc();
      cyc();

      // Reset state
      chk("rst_load_en", bus.load_en, 0);
      chk("rst_opcode", bus.opcode, 0);
      chk("rst_operand_a", bus.operand_a, 0);
      chk("rst_wptr", bus.write_pointer, 0);
      chk("rst_rptr", bus.read_pointer, 0);
      chk("rst_rd_valid", bus.rd_valid, 0);
      chk("rst_count", bus.count, 0);
      chk("rst_full", bus.full, 0);
      chk("rst_empty", bus.empty, 1);
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rd_ready", bus.rd_ready, 0);
      i_reset = 1'b0;

`ifdef INSTR_SCHED_CLEAR_EN
      // CLEAR: 32 zero loads, no grants even with a pending request
      set_req(0, OP_ADD, 32'd5, 32'd3);
      bus.req_valid = 2'b01;
      for (int k = 0; k < 32; k++) begin
         #1;
         chk("clr_req_ready", bus.req_ready, 0);
         chk("clr_rd_ready", bus.rd_ready, 0);
         cyc();
         chk("clr_load_en", bus.load_en, 1);
         chk("clr_wptr", bus.write_pointer, k);
         chk("clr_opcode", bus.opcode, 0);
      end
      #1;
      chk("clr_run_req_ready", bus.req_ready, 2'b01);
      bus.req_valid = 2'b00;
      cyc();
      chk("clr_done_load_en", bus.load_en, 0);
      chk("clr_done_count", bus.count, 0);
`endif

      // Single requester, three back-to-back loads
      set_req(0, OP_ADD, 32'd5, 32'd3);
      bus.req_valid = 2'b01;
      #1;
      chk("t1_ready_a", bus.req_ready, 2'b01);
      cyc();
      chk("t1_load_en_a", bus.load_en, 1);
      chk("t1_opcode_a", bus.opcode, OP_ADD);
      chk("t1_opa_a", bus.operand_a, 5);
      chk("t1_opb_a", bus.operand_b, 3);
      chk("t1_wptr_a", bus.write_pointer, 0);
      chk("t1_count_a", bus.count, 1);
      chk("t1_rd_ready", bus.rd_ready, 1);
      set_req(0, OP_SUB, 32'd9, 32'd2);
      #1;
      chk("t1_ready_b", bus.req_ready, 2'b01);
      cyc();
      chk("t1_load_en_b", bus.load_en, 1);
      chk("t1_opcode_b", bus.opcode, OP_SUB);
      chk("t1_opa_b", bus.operand_a, 9);
      chk("t1_wptr_b", bus.write_pointer, 1);
      set_req(0, OP_MULT, 32'd4, 32'd4);
      cyc();
      chk("t1_opcode_c", bus.opcode, OP_MULT);
      chk("t1_opb_c", bus.operand_b, 4);
      chk("t1_wptr_c", bus.write_pointer, 2);
      chk("t1_count_c", bus.count, 3);
      bus.req_valid = 2'b00;
      cyc();
      chk("t1_idle_load_en", bus.load_en, 0);
      chk("t1_idle_count", bus.count, 3);

      // Contention after reset: grants alternate 0,1,0,1
      i_reset = 1'b1;
      cyc();
      i_reset = 1'b0;
      chk("t2_rst_count", bus.count, 0);
      chk("t2_rst_empty", bus.empty, 1);
      set_req(0, OP_ADD, 32'd100, 32'd1);
      set_req(1, OP_SUB, 32'd200, 32'd2);
      bus.req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("t2_grant", bus.req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
         cyc();
         chk("t2_wptr", bus.write_pointer, k);
         chk("t2_opa", bus.operand_a, (k % 2 == 0) ? 100 : 200);
      end
      chk("t2_count", bus.count, 4);

      // Fill to 32, then one read frees a slot that wraps to pointer 0
      bus.req_valid = 2'b01;
      for (int k = 0; k < 28; k++) begin
         cyc();
      end
      chk("t3_count_full", bus.count, 32);
      chk("t3_full", bus.full, 1);
      chk("t3_wptr_last", bus.write_pointer, 31);
      #1;
      chk("t3_ready_full", bus.req_ready, 0);
      cyc();
      chk("t3_no_load_full", bus.load_en, 0);
      chk("t3_count_held", bus.count, 32);
      bus.rd_req = 1'b1;
      #1;
      chk("t3_rd_ready", bus.rd_ready, 1);
      cyc();
      chk("t3_rptr", bus.read_pointer, 0);
      chk("t3_rd_valid", bus.rd_valid, 1);
      chk("t3_count_after_rd", bus.count, 31);
      chk("t3_full_after_rd", bus.full, 0);
      bus.rd_req = 1'b0;
      #1;
      chk("t3_ready_again", bus.req_ready, 2'b01);
      cyc();
      chk("t3_wrap_load_en", bus.load_en, 1);
      chk("t3_wrap_wptr", bus.write_pointer, 0);
      chk("t3_wrap_count", bus.count, 32);
      chk("t3_rd_valid_pulse", bus.rd_valid, 0);
      bus.req_valid = 2'b00;

      // Simultaneous write+read at count 5, then drain and read while empty
      i_reset = 1'b1;
      cyc();
      i_reset = 1'b0;
      bus.req_valid = 2'b01;
      for (int k = 0; k < 5; k++) begin
         cyc();
      end
      bus.req_valid = 2'b00;
      chk("t4_count5", bus.count, 5);
      bus.req_valid = 2'b01;
      bus.rd_req    = 1'b1;
      cyc();
      chk("t4_sim_count_a", bus.count, 5);
      chk("t4_sim_wptr_a", bus.write_pointer, 5);
      chk("t4_sim_rptr_a", bus.read_pointer, 0);
      chk("t4_sim_rd_valid", bus.rd_valid, 1);
      cyc();
      chk("t4_sim_count_b", bus.count, 5);
      chk("t4_sim_wptr_b", bus.write_pointer, 6);
      chk("t4_sim_rptr_b", bus.read_pointer, 1);
      bus.req_valid = 2'b00;
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("t4_drain_rptr", bus.read_pointer, 2 + k);
      end
      chk("t4_drain_count", bus.count, 0);
      chk("t4_drain_empty", bus.empty, 1);
      #1;
      chk("t4_empty_rd_ready", bus.rd_ready, 0);
      cyc();
      chk("t4_empty_rd_valid_a", bus.rd_valid, 0);
      cyc();
      chk("t4_empty_rd_valid_b", bus.rd_valid, 0);
      chk("t4_empty_rptr", bus.read_pointer, 6);
      bus.rd_req = 1'b0;

      // Reset mid-stream during an accept; requester 0 wins first afterwards
      i_reset = 1'b1;
      cyc();
      i_reset = 1'b0;
      bus.req_valid = 2'b01;
      for (int k = 0; k < 7; k++) begin
         cyc();
      end
      chk("t5_count7", bus.count, 7);
      bus.req_valid = 2'b11;
      i_reset       = 1'b1;
      cyc();
      i_reset = 1'b0;
      chk("t5_load_en", bus.load_en, 0);
      chk("t5_count", bus.count, 0);
      chk("t5_empty", bus.empty, 1);
      chk("t5_wptr", bus.write_pointer, 0);
      set_req(0, OP_ADD, 32'd77, 32'd0);
      #1;
      chk("t5_first_grant", bus.req_ready, 2'b01);
      cyc();
      chk("t5_first_load", bus.load_en, 1);
      chk("t5_first_opa", bus.operand_a, 77);
      chk("t5_first_wptr", bus.write_pointer, 0);
      bus.req_valid = 2'b00;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
